// File: rtl/beam_sum_scheduler_pkg.sv
// rtl/beam_sum_scheduler_pkg.sv - shared state enum, default latencies and tag width helper
`ifndef ACC_WIDTH
`define ACC_WIDTH 48
`endif

package beam_sum_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  localparam int DEF_TREE_LAT   = 6;
  localparam int DEF_FIFO_DEPTH = 8;

  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bf_result_fifo.sv
// rtl/bf_result_fifo.sv - first-word-fall-through result FIFO, DEPTH a power of two >= 2
module bf_result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  assign dout  = mem_q[rptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/beam_sum_scheduler.sv
// rtl/beam_sum_scheduler.sv - round-robin issue scheduler for a shared accumulator tree with credit-managed result FIFO
// Optional per-requester issue counters on stat_issues when BF_SCHED_STATS_EN is defined.
`ifndef ACC_WIDTH
`define ACC_WIDTH 48
`endif

module beam_sum_scheduler
  import beam_sum_scheduler_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TREE_LAT   = DEF_TREE_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ACC_W      = `ACC_WIDTH,
  localparam int TW        = tag_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [TW-1:0]      tree_sel,
  output logic               tree_valid,
  input  logic [ACC_W-1:0]   sum_real,
  input  logic [ACC_W-1:0]   sum_imag,
  input  logic               sum_valid,
  output logic [ACC_W-1:0]   out_real,
  output logic [ACC_W-1:0]   out_imag,
  output logic [TW-1:0]      out_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               err_overflow
`ifdef BF_SCHED_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0] stat_issues
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(TREE_LAT + 1);
  localparam int FW = TW + 2 * ACC_W;

  sched_state_e  state_q, state_d;
  logic [TW-1:0] last_grant_q, grant_idx;
  logic          grant_found, issue;
  logic [CW-1:0] in_flight_q, in_flight_d, fifo_count;
  logic [TREE_LAT-1:0] sr_vld_q;
  logic [TW-1:0] sr_tag_q [TREE_LAT];
  logic [BW-1:0] blank_q;
  logic          err_q;
  logic          exit_vld, credit_ok, retire, orphan, push, pop;
  logic          fifo_empty, fifo_full, overflow_now;
  logic [FW-1:0] fifo_din, fifo_dout;
  int            cand;

  assign exit_vld  = sr_vld_q[TREE_LAT-1];
  assign credit_ok = ((CW+1)'(in_flight_q) + (CW+1)'(fifo_count)) < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[cand[TW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[TW-1:0];
      end
    end
  end

  assign issue      = (state_q == RUN) && en && grant_found && credit_ok;
  assign tree_valid = issue;
  assign tree_sel   = issue ? grant_idx : '0;
  assign req_ready  = issue ? (NUM_REQ'(1) << grant_idx) : '0;

  // Orphan results right after reset belong to issues that reset discarded.
  assign retire       = sum_valid && exit_vld;
  assign orphan       = sum_valid && !exit_vld && (blank_q == '0);
  assign pop          = out_valid && out_ready;
  assign push         = retire;
  assign overflow_now = orphan || (retire && fifo_full && !pop);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN: begin
        if (en) state_d = RUN;
        else if ((in_flight_q == '0) && fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_flight_d = in_flight_q;
    if (issue && !retire)      in_flight_d = in_flight_q + 1'b1;
    else if (!issue && retire) in_flight_d = in_flight_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= TW'(NUM_REQ - 1);
      in_flight_q  <= '0;
      blank_q      <= BW'(TREE_LAT);
      err_q        <= 1'b0;
      sr_vld_q     <= '0;
      for (int i = 0; i < TREE_LAT; i++) sr_tag_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= in_flight_d;
      if (issue)           last_grant_q <= grant_idx;
      if (blank_q != '0)   blank_q      <= blank_q - 1'b1;
      if (overflow_now)    err_q        <= 1'b1;
      sr_vld_q[0] <= issue;
      sr_tag_q[0] <= grant_idx;
      for (int i = 1; i < TREE_LAT; i++) begin
        sr_vld_q[i] <= sr_vld_q[i-1];
        sr_tag_q[i] <= sr_tag_q[i-1];
      end
    end
  end

  assign fifo_din = {sr_tag_q[TREE_LAT-1], sum_real, sum_imag};

  bf_result_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Head fields are masked so stale FIFO storage never shows on the outputs.
  assign out_valid    = !fifo_empty;
  assign out_tag      = out_valid ? fifo_dout[FW-1 -: TW] : '0;
  assign out_real     = out_valid ? fifo_dout[2*ACC_W-1 -: ACC_W] : '0;
  assign out_imag     = out_valid ? fifo_dout[ACC_W-1:0] : '0;
  assign busy         = (state_q != IDLE);
  assign err_overflow = err_q;

`ifdef BF_SCHED_STATS_EN
  logic [NUM_REQ-1:0][31:0] stat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stat_q <= '0;
    else if (issue) stat_q[grant_idx] <= stat_q[grant_idx] + 32'd1;
  end

  assign stat_issues = stat_q;
`endif

endmodule

// File: tb/tb_beam_sum_scheduler.sv
// tb/tb_beam_sum_scheduler.sv - randomized and directed bench for beam_sum_scheduler with a queue-based reference model
// Build with BF_SCHED_STATS_EN defined to also exercise stat_issues.
module tb_beam_sum_scheduler;

  localparam int N  = 4;
  localparam int TL = 6;
  localparam int D  = 8;
  localparam int AW = 48;

  typedef struct {
    logic [1:0]    tag;
    logic [AW-1:0] re;
    logic [AW-1:0] im;
  } res_t;

  logic clk = 1'b0;
  logic rst, en, sum_valid, out_ready;
  logic tree_valid, out_valid, busy, err_overflow;
  logic [N-1:0] req_valid, req_ready;
  logic [1:0] tree_sel, out_tag;
  logic [AW-1:0] sum_real, sum_imag, out_real, out_imag;
`ifdef BF_SCHED_STATS_EN
  logic [N-1:0][31:0] stat_issues;
`endif

  always #5 clk = ~clk;

  beam_sum_scheduler #(.NUM_REQ(N), .TREE_LAT(TL), .FIFO_DEPTH(D), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .tree_sel(tree_sel), .tree_valid(tree_valid), .sum_real(sum_real), .sum_imag(sum_imag),
    .sum_valid(sum_valid), .out_real(out_real), .out_imag(out_imag), .out_tag(out_tag),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err_overflow(err_overflow)
`ifdef BF_SCHED_STATS_EN
    , .stat_issues(stat_issues)
`endif
  );

  int errors = 0, checks = 0, cyc = 0, s_cyc = 0, n_issue = 0, n_pop = 0, last_g = N - 1;
  res_t exp_q[$];
  logic tv [TL];
  logic [AW-1:0] tr [TL], ti [TL];
  logic s_tv, s_ov, s_busy, s_err, s_pop;
  logic [N-1:0] s_rdy;
  logic [1:0] s_sel, s_tag;
  logic [AW-1:0] s_re, s_im;

  // Emulated tree plus scoreboard: every issue queues an expected result carrying the data the tree will return.
  task automatic cycle();
    int eg;
    res_t ne, pe;
    sum_valid = tv[TL-1];
    sum_real  = tr[TL-1];
    sum_imag  = ti[TL-1];
    #1;
    s_cyc = cyc;
    s_tv = tree_valid; s_sel = tree_sel; s_rdy = req_ready; s_ov = out_valid;
    s_tag = out_tag; s_re = out_real; s_im = out_imag; s_busy = busy; s_err = err_overflow;
    s_pop = s_ov && out_ready;
    ne.tag = '0; ne.re = '0; ne.im = '0;
    if (s_tv) begin
      eg = -1;
      for (int k = 1; k <= N; k++)
        if (eg < 0 && req_valid[(last_g + k) % N]) eg = (last_g + k) % N;
      checks++;
      if (eg < 0 || int'(s_sel) != eg || s_rdy !== N'(1 << eg) || exp_q.size() >= D) begin
        errors++;
        $display("FAIL grant cyc=%0d sel=%0d ready=%b expected sel=%0d outstanding=%0d limit=%0d",
                 s_cyc, s_sel, s_rdy, eg, exp_q.size(), D);
      end
      last_g = int'(s_sel);
      ne.tag = s_sel;
      ne.re  = AW'({$urandom(), $urandom()});
      ne.im  = AW'({$urandom(), $urandom()});
      exp_q.push_back(ne);
      n_issue++;
    end else begin
      checks++;
      if (s_rdy !== '0) begin
        errors++;
        $display("FAIL ready_without_issue cyc=%0d ready=%b expected 0", s_cyc, s_rdy);
      end
    end
    if (s_pop) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result cyc=%0d tag=%0d expected no result", s_cyc, s_tag);
      end else begin
        pe = exp_q.pop_front();
        if (s_tag !== pe.tag || s_re !== pe.re || s_im !== pe.im) begin
          errors++;
          $display("FAIL result cyc=%0d got tag=%0d re=%h im=%h expected tag=%0d re=%h im=%h",
                   s_cyc, s_tag, s_re, s_im, pe.tag, pe.re, pe.im);
        end
      end
      n_pop++;
    end
    @(posedge clk);
    for (int k = TL - 1; k > 0; k--) begin
      tv[k] = tv[k-1]; tr[k] = tr[k-1]; ti[k] = ti[k-1];
    end
    tv[0] = s_tv; tr[0] = ne.re; ti[0] = ne.im;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req_valid = '0; out_ready = 1'b0;
    exp_q.delete();
    last_g = N - 1;
    for (int k = 0; k < TL; k++) tv[k] = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
    repeat (TL + 1) cycle();
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    en = 1'b0; req_valid = '0; out_ready = 1'b1;
    do begin cycle(); c++; end while ((s_busy || exp_q.size() != 0) && c < 60);
    checks++;
    if (s_busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain busy=%0d outstanding=%0d expected idle and empty", name, s_busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req_valid = '1; out_ready = 1'b1;
    cycle();
    checks++;
    if ({s_busy, s_ov, s_tv, s_rdy, s_err, s_tag, s_re, s_im} !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%0d ov=%0d tv=%0d rdy=%b err=%0d re=%h expected all 0",
               s_busy, s_ov, s_tv, s_rdy, s_err, s_re);
    end
    rst = 1'b0; en = 1'b0; req_valid = '0;
    repeat (TL + 1) cycle();
    checks++;
    if (s_busy !== 1'b0 || s_ov !== 1'b0 || s_err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle busy=%0d ov=%0d err=%0d expected 0", s_busy, s_ov, s_err);
    end
  endtask

  task automatic test_round_robin();
    int gi, oi, first_g;
    gi = 0; oi = 0; first_g = -1000;
    en = 1'b1; req_valid = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      cycle();
      if (s_tv && gi < 5) begin
        if (gi == 0) first_g = s_cyc;
        checks++;
        if (int'(s_sel) != gi % N || s_cyc != first_g + gi) begin
          errors++;
          $display("FAIL rr_grant n=%0d sel=%0d cyc=%0d expected sel=%0d cyc=%0d", gi, s_sel, s_cyc, gi % N, first_g + gi);
        end
        gi++;
      end
      if (s_ov && oi < 5) begin
        checks++;
        if (int'(s_tag) != oi % N || s_cyc != first_g + TL + 1 + oi) begin
          errors++;
          $display("FAIL rr_out n=%0d tag=%0d cyc=%0d expected tag=%0d cyc=%0d", oi, s_tag, s_cyc, oi % N, first_g + TL + 1 + oi);
        end
        oi++;
      end
    end
    checks++;
    if (gi != 5 || oi != 5) begin
      errors++;
      $display("FAIL rr_counts grants=%0d outputs=%0d expected 5 and 5", gi, oi);
    end
    wait_idle("rr");
  endtask

  task automatic test_credit();
    int n0, p0;
    n0 = n_issue;
    en = 1'b1; req_valid = 4'b1111; out_ready = 1'b0;
    repeat (30) cycle();
    checks++;
    if (n_issue - n0 != D || s_rdy !== '0 || s_tv !== 1'b0 || s_err !== 1'b0 || s_ov !== 1'b1) begin
      errors++;
      $display("FAIL credit_stall issues=%0d rdy=%b err=%0d ov=%0d expected issues=%0d rdy=0 err=0 ov=1",
               n_issue - n0, s_rdy, s_err, s_ov, D);
    end
    req_valid = '0; out_ready = 1'b1; p0 = n_pop;
    repeat (12) cycle();
    checks++;
    if (n_pop - p0 != D) begin
      errors++;
      $display("FAIL credit_pops got=%0d expected=%0d", n_pop - p0, D);
    end
    wait_idle("credit");
  endtask

  task automatic test_drain();
    int n0, p0, c, extra;
    bit busy_ok;
    n0 = n_issue; c = 0; extra = 0; busy_ok = 1'b1;
    en = 1'b1; req_valid = 4'b1111; out_ready = 1'b0;
    while (n_issue - n0 < 3 && c < 20) begin cycle(); c++; end
    en = 1'b0;
    repeat (15) begin
      cycle();
      if (s_tv) extra++;
      if (!s_busy) busy_ok = 1'b0;
    end
    checks++;
    if (n_issue - n0 != 3 || extra != 0 || !busy_ok) begin
      errors++;
      $display("FAIL drain_hold issues=%0d extra=%0d busy_held=%0d expected 3 0 1", n_issue - n0, extra, busy_ok);
    end
    out_ready = 1'b1; p0 = n_pop; c = 0;
    do begin cycle(); c++; end while (s_busy && c < 30);
    checks++;
    if (n_pop - p0 != 3 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle pops=%0d busy=%0d expected 3 0", n_pop - p0, s_busy);
    end
  endtask

  task automatic test_reset_mid();
    int n0, c;
    bit quiet;
    n0 = n_issue; c = 0; quiet = 1'b1;
    en = 1'b1; req_valid = 4'b0010; out_ready = 1'b1;
    while (n_issue == n0 && c < 10) begin cycle(); c++; end
    en = 1'b0; req_valid = '0;
    cycle();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_before got=%0d expected 1", busy);
    end
    rst = 1'b1;
    exp_q.delete();
    last_g = N - 1;
    #1;
    checks++;
    if ({busy, out_valid, tree_valid, req_ready, err_overflow} !== '0) begin
      errors++;
      $display("FAIL mid_reset_async busy=%0d ov=%0d tv=%0d rdy=%b err=%0d expected all 0",
               busy, out_valid, tree_valid, req_ready, err_overflow);
    end
    cycle();
    rst = 1'b0;
    repeat (12) begin
      cycle();
      if (s_ov || s_err) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL mid_reset_late_sum ov=%0d err=%0d expected no output and no error", s_ov, s_err);
    end
  endtask

  task automatic test_inject();
    tv[TL-1] = 1'b1; tr[TL-1] = 48'h123456789abc; ti[TL-1] = 48'h0fedcba98765;
    cycle();
    cycle();
    checks++;
    if (s_err !== 1'b1) begin
      errors++;
      $display("FAIL inject_err got=%0d expected 1", s_err);
    end
    repeat (5) cycle();
    checks++;
    if (s_err !== 1'b1 || s_ov !== 1'b0) begin
      errors++;
      $display("FAIL inject_sticky err=%0d ov=%0d expected 1 0", s_err, s_ov);
    end
    do_reset();
    checks++;
    if (s_err !== 1'b0) begin
      errors++;
      $display("FAIL inject_clear err=%0d expected 0", s_err);
    end
  endtask

  task automatic test_random();
    int n0;
    n0 = n_issue;
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 15) != 0);
      cycle();
    end
    wait_idle("random");
    checks++;
    if (s_err !== 1'b0 || n_issue - n0 < 50) begin
      errors++;
      $display("FAIL random_summary err=%0d issues=%0d expected err=0 issues>=50", s_err, n_issue - n0);
    end
  endtask

`ifdef BF_SCHED_STATS_EN
  task automatic test_stats();
    int n0, c;
    do_reset();
    n0 = n_issue; c = 0;
    en = 1'b1; req_valid = 4'b0100; out_ready = 1'b1;
    while (n_issue - n0 < 10 && c < 40) begin cycle(); c++; end
    wait_idle("stats");
    for (int i = 0; i < N; i++) begin
      checks++;
      if (stat_issues[i] !== ((i == 2) ? 32'd10 : 32'd0)) begin
        errors++;
        $display("FAIL stat_issues[%0d] got=%0d expected=%0d", i, stat_issues[i], (i == 2) ? 10 : 0);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; req_valid = '0; out_ready = 1'b0;
    sum_valid = 1'b0; sum_real = '0; sum_imag = '0;
    for (int k = 0; k < TL; k++) begin tv[k] = 1'b0; tr[k] = '0; ti[k] = '0; end
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_credit();
    test_drain();
    test_reset_mid();
    test_inject();
    test_random();
`ifdef BF_SCHED_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
